// File: rtl/sc_r3_k3_2d.sv
// Streaming 5-point cross stencil (radius 1) over binary32 pixels, ST lanes per beat.
// Two beat-indexed line buffers supply N/C; a 5-stage datapath gives a fixed LAT=4 latency.
module sc_r3_k3_2d #(
   parameter int ROW = 16,
   parameter int COL = 20,
   parameter int ST  = 5,
   parameter int BW  = 32,
   parameter int LAT = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              din_ready,
   input  logic [ST*BW-1:0]  din,
   input  logic [ST*BW-1:0]  din_wt,
   output logic              dout_vld,
   output logic [ST*BW-1:0]  dout
);
   localparam int NB     = COL / ST;
   localparam int BEAT_W = (NB > 1) ? $clog2(NB) : 1;
   localparam int ROW_W  = $clog2(ROW);
   localparam int NTAP   = 5;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef logic [BW-1:0]         lane_t;
   typedef lane_t [ST-1:0]        beat_t;

   function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
      logic        sr, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, g, st;
      logic [47:0] prod;
      logic [23:0] m;
      logic [24:0] mr;
      int          e;
      sr     = a[31] ^ b[31];
      a_zero = (a[30:23] == 8'd0);
      b_zero = (b[30:23] == 8'd0);
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return QNAN;
      if (a_inf || b_inf) return {sr, 8'hFF, 23'd0};
      if (a_zero || b_zero) return {sr, 31'd0};
      prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      e    = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (prod[47]) begin
         m = prod[47:24]; g = prod[23]; st = |prod[22:0]; e = e + 1;
      end else begin
         m = prod[46:23]; g = prod[22]; st = |prod[21:0];
      end
      mr = {1'b0, m} + {24'd0, g & (st | m[0])};
      if (mr[24]) begin
         mr = mr >> 1; e = e + 1;
      end
      if (e >= 255) return {sr, 8'hFF, 23'd0};
      if (e <= 0) return {sr, 31'd0};
      return {sr, e[7:0], mr[22:0]};
   endfunction

   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x, y;
      logic [49:0] mx, my, mys;
      logic [50:0] sum;
      logic [23:0] m;
      logic [24:0] mr;
      logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, g, st, sticky, found;
      int          d, e, lz;
      a_zero = (a[30:23] == 8'd0);
      b_zero = (b[30:23] == 8'd0);
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      if (a_nan || b_nan) return QNAN;
      if (a_inf && b_inf) return (a[31] != b[31]) ? QNAN : a;
      if (a_inf) return a;
      if (b_inf) return b;
      if (a_zero && b_zero) return {a[31] & b[31], 31'd0};
      if (a_zero) return b;
      if (b_zero) return a;
      if (a[30:0] >= b[30:0]) begin
         x = a; y = b;
      end else begin
         x = b; y = a;
      end
      mx = {1'b1, x[22:0], 26'd0};
      my = {1'b1, y[22:0], 26'd0};
      d  = int'(x[30:23]) - int'(y[30:23]);
      if (d > 49) begin
         mys = 50'd0; sticky = 1'b1;
      end else begin
         mys = my >> d; sticky = ((mys << d) != my);
      end
      // Shifted-out bits collapse into the LSB so subtraction still rounds correctly.
      mys[0] = mys[0] | sticky;
      e = int'(x[30:23]);
      if (x[31] == y[31]) sum = {1'b0, mx} + {1'b0, mys};
      else                sum = {1'b0, mx} - {1'b0, mys};
      if (sum == 51'd0) return 32'd0;
      if (sum[50]) begin
         m = sum[50:27]; g = sum[26]; st = |sum[25:0]; e = e + 1;
      end else begin
         lz = 0; found = 1'b0;
         for (int i = 49; i >= 0; i--) begin
            if (!found) begin
               if (sum[i]) found = 1'b1;
               else        lz = lz + 1;
            end
         end
         sum = sum << lz;
         e   = e - lz;
         m = sum[49:26]; g = sum[25]; st = |sum[24:0];
      end
      mr = {1'b0, m} + {24'd0, g & (st | m[0])};
      if (mr[24]) begin
         mr = mr >> 1; e = e + 1;
      end
      if (e >= 255) return {x[31], 8'hFF, 23'd0};
      if (e <= 0) return {x[31], 31'd0};
      return {x[31], e[7:0], mr[22:0]};
   endfunction

   logic [BEAT_W-1:0] beat_q, beat_d, nxt_beat;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [LAT:0]      vld_q, vld_d;
   beat_t             dout_q, dout_d;
   beat_t             lb1_q [NB], lb1_d [NB];
   beat_t             lb2_q [NB], lb2_d [NB];
   beat_t             prev_c_q, prev_c_d;
   beat_t             c_b, n_b, s_b, wt_b;
   lane_t             w_edge, e_edge;
   lane_t             op_q [ST][NTAP], op_d [ST][NTAP];
   lane_t             wt_q [NTAP], wt_d [NTAP];
   lane_t             prod_q [ST][NTAP], prod_d [ST][NTAP];
   lane_t             s3_q [ST], s3_d [ST], p3_q [ST], p3_d [ST], p4a_q [ST], p4a_d [ST];
   lane_t             s4_q [ST], s4_d [ST], p4b_q [ST], p4b_d [ST];
   logic              last_beat;

   // NOTE: every variable written here gets a default first, so no path can infer a latch.
   always_comb begin
      beat_d    = beat_q;
      row_d     = row_q;
      last_beat = (beat_q == BEAT_W'(NB - 1));
      if (din_ready) begin
         if (last_beat) begin
            beat_d = '0;
            row_d  = (row_q == ROW_W'(ROW - 1)) ? '0 : row_q + ROW_W'(1);
         end else begin
            beat_d = beat_q + BEAT_W'(1);
         end
      end
      vld_d = {vld_q[LAT-1:0], din_ready && (row_q >= ROW_W'(2))};
   end

   // Incoming row r+1 beat b: lb1 holds row r, lb2 row r-1; prev_c keeps row r beat b-1,
   // whose lb1 slot was already overwritten by the previous incoming beat.
   always_comb begin
      lb1_d    = lb1_q;
      lb2_d    = lb2_q;
      prev_c_d = prev_c_q;
      nxt_beat = last_beat ? '0 : beat_q + BEAT_W'(1);
      c_b      = lb1_q[beat_q];
      n_b      = lb2_q[beat_q];
      s_b      = din;
      wt_b     = din_wt;
      w_edge   = (beat_q == '0) ? '0 : prev_c_q[ST-1];
      e_edge   = last_beat ? '0 : lb1_q[nxt_beat][0];
      if (din_ready) begin
         lb2_d[beat_q] = lb1_q[beat_q];
         lb1_d[beat_q] = din;
         prev_c_d      = lb1_q[beat_q];
      end
      for (int l = 0; l < ST; l++) begin
         op_d[l][0] = n_b[l];
         op_d[l][2] = c_b[l];
         op_d[l][4] = s_b[l];
      end
      op_d[0][1]    = w_edge;
      op_d[ST-1][3] = e_edge;
      for (int l = 1; l < ST; l++)      op_d[l][1] = c_b[l-1];
      for (int l = 0; l < ST - 1; l++)  op_d[l][3] = c_b[l+1];
      for (int k = 0; k < NTAP; k++)    wt_d[k] = wt_b[k];
   end

   always_comb begin
      dout_d = dout_q;
      for (int l = 0; l < ST; l++) begin
         for (int k = 0; k < NTAP; k++) prod_d[l][k] = fp_mul(op_q[l][k], wt_q[k]);
         s3_d[l]  = fp_add(fp_add(prod_q[l][0], prod_q[l][1]), prod_q[l][2]);
         p3_d[l]  = prod_q[l][3];
         p4a_d[l] = prod_q[l][4];
         s4_d[l]  = fp_add(s3_q[l], p3_q[l]);
         p4b_d[l] = p4a_q[l];
         if (vld_q[LAT-1]) dout_d[l] = fp_add(s4_q[l], p4b_q[l]);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         beat_q <= '0;
         row_q  <= '0;
         vld_q  <= '0;
         dout_q <= '0;
      end else begin
         beat_q <= beat_d;
         row_q  <= row_d;
         vld_q  <= vld_d;
         dout_q <= dout_d;
      end
   end

   // NOTE: line buffers and datapath stages carry no reset; valid bits alone qualify them.
   always_ff @(posedge clock) begin
      lb1_q    <= lb1_d;
      lb2_q    <= lb2_d;
      prev_c_q <= prev_c_d;
      op_q     <= op_d;
      wt_q     <= wt_d;
      prod_q   <= prod_d;
      s3_q     <= s3_d;
      p3_q     <= p3_d;
      p4a_q    <= p4a_d;
      s4_q     <= s4_d;
      p4b_q    <= p4b_d;
   end

   assign dout_vld = vld_q[LAT];
   assign dout     = dout_q;

endmodule

// File: tb/tb_sc_r3_k3_2d.sv
// Self-checking bench for sc_r3_k3_2d: integer-valued frames, expected beats queued
// at trigger time from an integer reference and compared (data and cycle) on dout_vld.
module tb_sc_r3_k3_2d;
   localparam int ROW = 16, COL = 20, ST = 5, BW = 32, LAT = 4;
   localparam int NB  = COL / ST;
   localparam int FRAME_BEATS = ROW * NB;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             din_ready = 1'b0;
   logic [ST*BW-1:0] din = '0, din_wt = '0;
   logic             dout_vld;
   logic [ST*BW-1:0] dout;

   sc_r3_k3_2d #(.ROW(ROW), .COL(COL), .ST(ST), .BW(BW), .LAT(LAT)) dut (
      .clock(clock), .reset(reset), .din_ready(din_ready), .din(din),
      .din_wt(din_wt), .dout_vld(dout_vld), .dout(dout)
   );

   always #5 clock = ~clock;

   int unsigned cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_checks = 0, n_fail = 0;

   task automatic check(input string name, input logic [ST*BW-1:0] act, input logic [ST*BW-1:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   typedef struct {
      logic [ST*BW-1:0] data;
      int unsigned      cyc;
      int               r;
      int               b;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      string name;
      int    pat;
      int    gap;
      int    frames;
      int    pulses;
   } case_t;
   case_t tc[6];

   int               n_pulses = 0;
   bit               first_seen = 1'b0;
   logic [ST*BW-1:0] first_dout = '0;
   logic [ST*BW-1:0] last_dout = '0;

   function automatic int pix(int pat, int fr, int r, int c);
      case (pat)
         0:       return 1;
         1:       return r;
         2:       return (r == 5 && c == 7) ? 1 : 0;
         default: return ((r * 31 + c * 17 + fr * 13) % 17) - 8;
      endcase
   endfunction

   function automatic int wt(int pat, int fr, int r, int b, int k);
      case (pat)
         2:       return k + 1;
         3:       return 1 + ((r * 7 + b * 3 + k + fr) % 4);
         default: return 1;
      endcase
   endfunction

   function automatic logic [31:0] i2f(int v);
      logic [31:0] f;
      int mag, p;
      f = '0;
      if (v == 0) return f;
      mag = (v < 0) ? -v : v;
      p = 0;
      for (int i = 0; i < 24; i++) if (mag >= (1 << i)) p = i;
      f[31]    = (v < 0);
      f[30:23] = 8'(127 + p);
      f[22:0]  = 23'((mag << (23 - p)) & 32'h007F_FFFF);
      return f;
   endfunction

   task automatic drive_beat(input int pat, input int fr, input int r, input int b);
      logic [ST*BW-1:0] px, w;
      exp_t e;
      int ro, c, sum;
      px = '0;
      w  = '0;
      for (int l = 0; l < ST; l++) px[l*BW +: BW] = i2f(pix(pat, fr, r, b * ST + l));
      for (int k = 0; k < 5; k++)  w[k*BW +: BW]  = i2f(wt(pat, fr, r, b, k));
      if (r >= 2) begin
         ro     = r - 1;
         e.data = '0;
         for (int l = 0; l < ST; l++) begin
            c   = b * ST + l;
            sum = wt(pat, fr, r, b, 0) * pix(pat, fr, ro - 1, c)
                + wt(pat, fr, r, b, 1) * ((c > 0) ? pix(pat, fr, ro, c - 1) : 0)
                + wt(pat, fr, r, b, 2) * pix(pat, fr, ro, c)
                + wt(pat, fr, r, b, 3) * ((c < COL - 1) ? pix(pat, fr, ro, c + 1) : 0)
                + wt(pat, fr, r, b, 4) * pix(pat, fr, ro + 1, c);
            e.data[l*BW +: BW] = i2f(sum);
         end
         e.cyc = cyc + 1 + LAT;
         e.r   = ro;
         e.b   = b;
         sbq.push_back(e);
      end
      din       = px;
      din_wt    = w;
      din_ready = 1'b1;
      @(negedge clock);
      din_ready = 1'b0;
   endtask

   task automatic send(input int pat, input int fr, input int gap, input int nbeats);
      for (int i = 0; i < nbeats; i++) begin
         drive_beat(pat, fr + i / FRAME_BEATS, (i / NB) % ROW, i % NB);
         if (gap == 1)      @(negedge clock);
         else if (gap == 2) repeat ($urandom_range(0, 2)) @(negedge clock);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clock);
      if (sbq.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expected outputs never appeared", sbq.size());
         sbq.delete();
      end
      repeat (8) @(negedge clock);
   endtask

   // Monitor: reset state, scoreboard pops with latency check, and hold when idle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset) begin
            check("reset dout_vld", {{(ST*BW-1){1'b0}}, dout_vld}, '0);
            check("reset dout", dout, '0);
            last_dout = '0;
         end else if (dout_vld) begin
            n_pulses++;
            if (!first_seen) begin
               first_seen = 1'b1;
               first_dout = dout;
            end
            if (sbq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL spurious dout_vld at cycle %0d: got pulse, expected none", cyc);
            end else begin
               e = sbq.pop_front();
               check($sformatf("data r%0d b%0d", e.r, e.b), dout, e.data);
               check($sformatf("latency r%0d b%0d", e.r, e.b), ST*BW'(cyc), ST*BW'(e.cyc));
            end
            last_dout = dout;
         end else begin
            check("dout hold", dout, last_dout);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tc[0] = '{name: "ones",        pat: 0, gap: 0, frames: 1, pulses: 56};
      tc[1] = '{name: "row_index",   pat: 1, gap: 0, frames: 1, pulses: 56};
      tc[2] = '{name: "impulse",     pat: 2, gap: 0, frames: 1, pulses: 56};
      tc[3] = '{name: "ones_toggle", pat: 0, gap: 1, frames: 1, pulses: 56};
      tc[4] = '{name: "two_frames",  pat: 3, gap: 0, frames: 2, pulses: 112};
      tc[5] = '{name: "rand_gaps",   pat: 3, gap: 2, frames: 1, pulses: 56};

      #1 reset = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      for (int i = 0; i < 6; i++) begin
         n_pulses   = 0;
         first_seen = 1'b0;
         send(tc[i].pat, 10 * i, tc[i].gap, tc[i].frames * FRAME_BEATS);
         drain();
         check({tc[i].name, " pulse count"}, ST*BW'(n_pulses), ST*BW'(tc[i].pulses));
         if (i == 0)
            check("ones first beat", first_dout,
                  {32'h40A0_0000, 32'h40A0_0000, 32'h40A0_0000, 32'h40A0_0000, 32'h4080_0000});
      end

      // Reset in the middle of row 4, then a clean frame must come out unaffected.
      send(3, 50, 0, 4 * NB + 2);
      @(posedge clock);
      #1 reset = 1'b0;
      sbq.delete();
      repeat (3) @(negedge clock);
      reset      = 1'b1;
      n_pulses   = 0;
      first_seen = 1'b0;
      @(negedge clock);
      send(3, 60, 0, FRAME_BEATS);
      drain();
      check("post-reset pulse count", ST*BW'(n_pulses), ST*BW'(56));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
